// File: rtl/text_console_ctrl.sv
// Write-port sequencer for the 80x25 text VRAM: console commands become char/attr writes, clear and scroll.
// Optional CONSOLE_SCROLL_EN builds the scroll engine; without it cursor overflow wraps to cell 0.
`timescale 1ns/1ps

module text_console_ctrl #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 25,
    parameter logic [7:0] DEF_ATTR = 8'h07
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [10:0] cmd_data,
    output logic [11:0] vram_address,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic [10:0] cursor,
    output logic [7:0]  attr,
    output logic        busy
);

    localparam logic [1:0] OP_PUTC    = 2'd0;
    localparam logic [1:0] OP_SETCUR  = 2'd1;
    localparam logic [1:0] OP_SETATTR = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [10:0] COLS_C     = 11'(COLS);
    localparam logic [11:0] COLS_W     = 12'(COLS);
    localparam logic [11:0] CELLS_W    = 12'(COLS * ROWS);
    localparam logic [10:0] LAST_CELL  = 11'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_BYTE  = 12'(2 * COLS * ROWS - 1);
`ifdef CONSOLE_SCROLL_EN
    localparam logic [10:0] LAST_ROW_C = 11'(COLS * (ROWS - 1));
    localparam logic [11:0] ROW_BYTES  = 12'(2 * COLS);
    localparam logic [11:0] COPY_LAST  = 12'(2 * COLS * (ROWS - 1) - 1);
    localparam logic [11:0] COPY_BYTES = 12'(2 * COLS * (ROWS - 1));
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_CHAR,
        WR_ATTR,
`ifdef CONSOLE_SCROLL_EN
        SCR_RD,
        SCR_WR,
`endif
        FILL
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cursor_q, cursor_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  char_q, char_d;
    logic [11:0] idx_q, idx_d;
    logic [10:0] fill_cur_q, fill_cur_d;

    logic [10:0] col;
    logic [11:0] nxt_cur;
    logic        ovf;

`ifndef CONSOLE_SCROLL_EN
    logic unused_rdata;
    assign unused_rdata = ^vram_rdata;
`endif

    assign col    = cursor_q % COLS_C;
    assign cursor = cursor_q;
    assign attr   = attr_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        attr_d       = attr_q;
        char_d       = char_q;
        idx_d        = idx_q;
        fill_cur_d   = fill_cur_q;
        nxt_cur      = {1'b0, cursor_q};
        ovf          = 1'b0;
        cmd_ready    = (state_q == IDLE);
        vram_we      = 1'b0;
        vram_address = '0;
        vram_wdata   = '0;
        busy         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_PUTC: begin
                            unique case (cmd_data[7:0])
                                8'h0D: cursor_d = cursor_q - col;
                                8'h0A: begin
                                    nxt_cur = {1'b0, cursor_q} + COLS_W - {1'b0, col};
                                    if (nxt_cur == CELLS_W) ovf = 1'b1;
                                    else                    cursor_d = nxt_cur[10:0];
                                end
                                8'h08: if (cursor_q != '0) cursor_d = cursor_q - 11'd1;
                                default: begin
                                    char_d  = cmd_data[7:0];
                                    state_d = WR_CHAR;
                                end
                            endcase
                        end
                        OP_SETCUR:  cursor_d = (cmd_data > LAST_CELL) ? LAST_CELL : cmd_data;
                        OP_SETATTR: attr_d   = cmd_data[7:0];
                        OP_CLEAR: begin
                            idx_d      = '0;
                            fill_cur_d = '0;
                            state_d    = FILL;
                        end
                    endcase
                end
            end
            WR_CHAR: begin
                vram_we      = 1'b1;
                vram_address = {cursor_q, 1'b0};
                vram_wdata   = char_q;
                state_d      = WR_ATTR;
            end
            WR_ATTR: begin
                vram_we      = 1'b1;
                vram_address = {cursor_q, 1'b1};
                vram_wdata   = attr_q;
                nxt_cur      = {1'b0, cursor_q} + 12'd1;
                state_d      = IDLE;
                if (nxt_cur == CELLS_W) ovf = 1'b1;
                else                    cursor_d = nxt_cur[10:0];
            end
`ifdef CONSOLE_SCROLL_EN
            SCR_RD: begin
                busy         = 1'b1;
                vram_address = idx_q + ROW_BYTES;
                state_d      = SCR_WR;
            end
            SCR_WR: begin
                // Read data for the row below arrives one cycle after SCR_RD issued its address.
                busy         = 1'b1;
                vram_we      = 1'b1;
                vram_address = idx_q;
                vram_wdata   = vram_rdata;
                if (idx_q == COPY_LAST) begin
                    idx_d   = COPY_BYTES;
                    state_d = FILL;
                end else begin
                    idx_d   = idx_q + 12'd1;
                    state_d = SCR_RD;
                end
            end
`endif
            FILL: begin
                busy         = 1'b1;
                vram_we      = 1'b1;
                vram_address = idx_q;
                vram_wdata   = idx_q[0] ? attr_q : 8'h20;
                if (idx_q == LAST_BYTE) begin
                    cursor_d = fill_cur_q;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cursor would land one past the last cell: scroll or wrap.
        if (ovf) begin
`ifdef CONSOLE_SCROLL_EN
            idx_d      = '0;
            fill_cur_d = LAST_ROW_C;
            state_d    = SCR_RD;
`else
            cursor_d   = '0;
            state_d    = IDLE;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cursor_q   <= '0;
            attr_q     <= DEF_ATTR;
            char_q     <= '0;
            idx_q      <= '0;
            fill_cur_q <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            attr_q     <= attr_d;
            char_q     <= char_d;
            idx_q      <= idx_d;
            fill_cur_q <= fill_cur_d;
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: predicted VRAM writes are queued at stimulus time and
// compared as the DUT issues them; behaviour follows CONSOLE_SCROLL_EN when defined.
`timescale 1ns/1ps

module tb_text_console_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int BYTES = 2 * COLS * ROWS;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [10:0] cmd_data;
    logic [11:0] vram_address;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [10:0] cursor;
    logic [7:0]  attr;
    logic        busy;

    text_console_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .vram_address (vram_address),
        .vram_we      (vram_we),
        .vram_wdata   (vram_wdata),
        .vram_rdata   (vram_rdata),
        .cursor       (cursor),
        .attr         (attr),
        .busy         (busy)
    );

    always #20 clock = ~clock;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0] vram    [0:4095];
    logic [7:0] exp_mem [0:4095];
    wr_t        exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int busy_cyc, nrdy_cyc, rd_cyc;
    int m_cursor;
    logic [7:0] m_attr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // VRAM: synchronous write, one-cycle read latency
    always @(posedge clock) begin
        if (vram_we) vram[vram_address] <= vram_wdata;
        vram_rdata <= vram[vram_address];
    end

    always @(negedge clock) begin
        if (busy) busy_cyc++;
        if (!cmd_ready) nrdy_cyc++;
        if (!cmd_ready && !vram_we) rd_cyc++;
        if (vram_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {20'd0, vram_address}, 32'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, vram_address}, {20'd0, e.a});
                check("wr_data", {24'd0, vram_wdata}, {24'd0, e.d});
            end
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.a = 12'(a);
        e.d = d;
        exp_q.push_back(e);
        exp_mem[a] = d;
    endtask

    task automatic model_fill(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) push_wr(a, (a % 2 == 1) ? m_attr : 8'h20);
    endtask

    task automatic model_overflow();
`ifdef CONSOLE_SCROLL_EN
        for (int i = 0; i < 2 * COLS * (ROWS - 1); i++) push_wr(i, exp_mem[i + 2 * COLS]);
        model_fill(2 * COLS * (ROWS - 1), BYTES - 1);
        m_cursor = COLS * (ROWS - 1);
`else
        m_cursor = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int limit);
        int t = 0;
        while (!cmd_ready && t < limit) begin
            tick();
            t++;
        end
        if (!cmd_ready) check(tag, 32'd0, 32'd1);
    endtask

    // Returns in the cycle after the accept edge.
    task automatic send(input logic [1:0] op, input logic [10:0] data);
        wait_ready("send_timeout", 10000);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic cmp_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < BYTES; a++) if (vram[a] !== exp_mem[a]) bad++;
        check(tag, bad, 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [10:0] data;
        int          exp_cur;
    } cur_vec_t;

    cur_vec_t cur_tab[10];

    initial begin
        #(40 * 80000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        m_cursor  = 0;
        m_attr    = 8'h07;
        for (int a = 0; a < 4096; a++) begin
            vram[a]    = 8'($urandom);
            exp_mem[a] = vram[a];
        end

        // Reset state
        repeat (3) tick();
        check("rst_cursor", {21'd0, cursor}, 0);
        check("rst_attr", {24'd0, attr}, 32'h07);
        check("rst_we", {31'd0, vram_we}, 0);
        check("rst_addr", {20'd0, vram_address}, 0);
        check("rst_wdata", {24'd0, vram_wdata}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        reset_n = 1'b1;
        tick();
        check("rst_ready", {31'd0, cmd_ready}, 1);

        // PUTC 'A' cycle by cycle
        push_wr(0, 8'h41);
        push_wr(1, 8'h07);
        send(2'd0, 11'h041);
        check("putc_n1_we", {31'd0, vram_we}, 1);
        check("putc_n1_addr", {20'd0, vram_address}, 0);
        check("putc_n1_ready", {31'd0, cmd_ready}, 0);
        tick();
        check("putc_n2_we", {31'd0, vram_we}, 1);
        check("putc_n2_addr", {20'd0, vram_address}, 1);
        tick();
        check("putc_n3_ready", {31'd0, cmd_ready}, 1);
        check("putc_cursor", {21'd0, cursor}, 1);
        m_cursor = 1;

        // Cursor commands and control codes (11'h7FF is the widest SETCUR, clamps to 1999)
        cur_tab[0] = '{2'd1, 11'd85,   85};
        cur_tab[1] = '{2'd0, 11'h00D,  80};
        cur_tab[2] = '{2'd1, 11'd85,   85};
        cur_tab[3] = '{2'd0, 11'h00A,  160};
        cur_tab[4] = '{2'd0, 11'h008,  159};
        cur_tab[5] = '{2'd1, 11'd0,    0};
        cur_tab[6] = '{2'd0, 11'h008,  0};
        cur_tab[7] = '{2'd1, 11'h7FF,  1999};
        cur_tab[8] = '{2'd0, 11'h00D,  1920};
        cur_tab[9] = '{2'd1, 11'h7FF,  1999};
        for (int i = 0; i < 10; i++) begin
            send(cur_tab[i].op, cur_tab[i].data);
            check($sformatf("cur_%0d", i), {21'd0, cursor}, cur_tab[i].exp_cur);
            check($sformatf("cur_rdy_%0d", i), {31'd0, cmd_ready}, 1);
            m_cursor = cur_tab[i].exp_cur;
        end

        // Printable char at the last cell overflows
        busy_cyc = 0;
        rd_cyc   = 0;
        push_wr(2 * m_cursor, 8'h58);
        push_wr(2 * m_cursor + 1, m_attr);
        model_overflow();
        send(2'd0, 11'h058);
        wait_ready("ovf_putc_timeout", 10000);
        check("ovf_putc_cursor", {21'd0, cursor}, m_cursor);
`ifdef CONSOLE_SCROLL_EN
        check("ovf_putc_busy", busy_cyc, 7840);
        check("ovf_putc_reads", rd_cyc, 2 * COLS * (ROWS - 1));
`else
        check("ovf_putc_busy", busy_cyc, 0);
        check("ovf_putc_reads", rd_cyc, 0);
`endif
        check("ovf_putc_q", exp_q.size(), 0);
        cmp_mem("ovf_putc_mem");

        // Line feed on the last row overflows too
        send(2'd1, 11'd1950);
        m_cursor = 1950;
        model_overflow();
        send(2'd0, 11'h00A);
        wait_ready("ovf_lf_timeout", 10000);
        check("ovf_lf_cursor", {21'd0, cursor}, m_cursor);
        check("ovf_lf_q", exp_q.size(), 0);
        cmp_mem("ovf_lf_mem");

        // SETATTR then CLEAR with a command held while busy
        send(2'd2, 11'h01E);
        check("setattr", {24'd0, attr}, 32'h1E);
        m_attr   = 8'h1E;
        nrdy_cyc = 0;
        model_fill(0, BYTES - 1);
        m_cursor = 0;
        send(2'd3, 11'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_data  = 11'h055;
        wait_ready("clear_timeout", 10000);
        cmd_valid = 1'b0;
        check("clear_notready", nrdy_cyc, 4000);
        check("clear_attr_kept", {24'd0, attr}, 32'h1E);
        check("clear_cursor", {21'd0, cursor}, 0);
        check("clear_q", exp_q.size(), 0);
        cmp_mem("clear_mem");

        // Reset in the middle of a CLEAR, just before byte 1000 is written
        send(2'd1, 11'd500);
        check("pre_rst_cursor", {21'd0, cursor}, 500);
        model_fill(0, 999);
        send(2'd3, 11'd0);
        for (int t = 0; t < 5000 && vram_address != 12'd1000; t++) tick();
        check("mid_clear_addr", {20'd0, vram_address}, 1000);
        reset_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, vram_we}, 0);
        check("midrst_cursor", {21'd0, cursor}, 0);
        check("midrst_attr", {24'd0, attr}, 32'h07);
        check("midrst_busy", {31'd0, busy}, 0);
        m_cursor = 0;
        m_attr   = 8'h07;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("midrst_ready", {31'd0, cmd_ready}, 1);
        check("midrst_q", exp_q.size(), 0);
        cmp_mem("midrst_mem");

        // Normal operation after the abandoned clear
        push_wr(0, 8'h5A);
        push_wr(1, 8'h07);
        send(2'd0, 11'h05A);
        wait_ready("post_timeout", 100);
        repeat (4) tick();
        check("post_cursor", {21'd0, cursor}, 1);
        check("post_q", exp_q.size(), 0);
        cmp_mem("post_mem");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
